axi4_lite_cmd_master: RTL and testbench
=======================================

Name: axi4_lite_cmd_master

Overview:
AXI4-Lite initiator that turns single-beat register commands into complete AXI4-Lite write or read transactions, then returns the response. It drives the CSR slaves in the image-processing pipeline (demosaicing, etc.) from a boot sequencer or host bridge. It handles one outstanding transaction at a time and keeps error statistics.

Parameters:
ADDR_W, 32, width of awaddr/araddr and cmd_addr_i
ERR_CNT_W, 16, width of the saturating error counter

Ports:
clk_i  in  1  single clock
rst_n_i  in  1  asynchronous, active-low reset
cmd_valid_i  in  1  command valid
cmd_ready_o  out  1  command accepted when valid&&ready
cmd_write_i  in  1  1 = write, 0 = read
cmd_addr_i  in  ADDR_W  byte address
cmd_wdata_i  in  32  write data
cmd_wstrb_i  in  4  write strobes
rsp_valid_o  out  1  response valid
rsp_ready_i  in  1  response consumed when valid&&ready
rsp_write_o  out  1  echo of the command type
rsp_rdata_o  out  32  read data; 0 for writes
rsp_resp_o  out  2  bresp or rresp
busy_o  out  1  high whenever state != IDLE
err_cnt_o  out  ERR_CNT_W  saturating count of non-OKAY responses
csr_o  axi4_lite_if.master  -  AXI4-Lite bus toward the slaves

Behaviour:
- Reset (rst_n_i low, async): state IDLE; awvalid, wvalid, arvalid, bready, rready, rsp_valid_o = 0; all address/data/strb/rsp registers = 0; err_cnt_o = 0. cmd_ready_o = 1 only in IDLE, so it is 1 after reset.
- All AXI outputs are registered. arprot/awprot = 3'b000.
- States:
  - IDLE: cmd_ready_o = 1. On cmd handshake, latch addr/data/strb/write.
    - Write: go to WR with awvalid = 1 and wvalid = 1 from the next cycle.
    - Read: go to RD_A with arvalid = 1.
  - WR: awvalid drops on the cycle after its aw handshake; wvalid drops on the cycle after its w handshake. The two handshakes are independent and may occur in the same cycle or in either order. When both are complete, go to WR_B with bready = 1. awaddr, wdata and wstrb stay stable while their valid is high.
  - WR_B: on b handshake, capture bresp, set rsp_rdata = 0, deassert bready, go to RSP.
  - RD_A: on ar handshake, deassert arvalid, assert rready, go to RD_D.
  - RD_D: on r handshake, capture rdata and rresp, deassert rready, go to RSP.
  - RSP: rsp_valid_o = 1 and held stable until rsp_ready_i. On rsp handshake, go to IDLE; cmd_ready_o returns to 1 the following cycle.
- Latency against a zero-wait slave (awready = wready = arready = 1, bvalid/rvalid one cycle after the handshake):
  - Write: cmd handshake at cycle 0, aw/w handshake at cycle 1, b handshake at cycle 2, rsp_valid_o at cycle 3.
  - Read: ar handshake at cycle 1, rvalid at cycle 2, r handshake at cycle 2, rsp_valid_o at cycle 3.
- bvalid or rvalid arriving before bready/rready is asserted is legal; it is consumed once the ready rises.
- err_cnt_o increments by 1 on every b or r handshake with resp != 2'b00 and saturates at all-ones.
- No timeout: a non-responding slave keeps busy_o = 1 indefinitely. Recovery is by reset only.
- Reset mid-transaction: all valids/readies drop immediately (async) and the in-flight command is lost. A system-level reset of the slaves is required alongside.

Decomposition:
- Package axi4_lite_cmd_master_pkg:
  - state enum (IDLE, WR, WR_B, RD_A, RD_D, RSP)
  - response constants RESP_OKAY = 2'b00, RESP_EXOKAY = 2'b01, RESP_SLVERR = 2'b10, RESP_DECERR = 2'b11
- No sub-module; one FSM plus datapath registers.

Test Plan:
- Write 0x0000_0001 to 0x0, wstrb 0xF, against a zero-wait slave model -> one aw and one w handshake; rsp_valid_o at cycle 3 with rsp_resp_o = 0, rsp_write_o = 1; slave reg0 = 1.
- Read 0x4 with slave reg1 = 0x3 -> rsp_rdata_o = 0x0000_0003, rsp_resp_o = 0, rsp_write_o = 0; arvalid high for exactly one cycle.
- Slave delays wready by 3 cycles after awready -> awvalid drops after its handshake, wvalid stays high with wdata stable until the w handshake; exactly one bready handshake; data written correctly.
- Slave returns bresp = 2'b10 on 3 consecutive writes, then OKAY -> err_cnt_o = 3, rsp_resp_o = 2'b10 on the first three responses.
- rsp_ready_i held low for 10 cycles with cmd_valid_i high -> rsp_valid_o and rsp data stable, cmd_ready_o = 0, no new AXI activity; second command accepted the cycle after the rsp handshake.
- Assert rst_n_i low while in WR_B -> bready, awvalid and wvalid = 0 immediately; after release, cmd_ready_o = 1, err_cnt_o = 0, busy_o = 0.

Source files
------------

// File: rtl/axi4_lite_cmd_master_pkg.sv
// Shared types and constants for the AXI4-Lite command master.
// State encoding, AXI response codes and a response classification helper.
package axi4_lite_cmd_master_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WR   = 3'd1,
    WR_B = 3'd2,
    RD_A = 3'd3,
    RD_D = 3'd4,
    RSP  = 3'd5
  } state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Anything but OKAY counts toward the error statistics, EXOKAY included.
  function automatic logic resp_is_err(input logic [1:0] resp);
    return resp != RESP_OKAY;
  endfunction

endpackage

// File: rtl/axi4_lite_if.sv
// AXI4-Lite bus bundle with master and slave views.
interface axi4_lite_if #(
  parameter int ADDR_W = 32
);

  logic [ADDR_W-1:0] awaddr;
  logic [2:0]        awprot;
  logic              awvalid;
  logic              awready;
  logic [31:0]       wdata;
  logic [3:0]        wstrb;
  logic              wvalid;
  logic              wready;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;
  logic [ADDR_W-1:0] araddr;
  logic [2:0]        arprot;
  logic              arvalid;
  logic              arready;
  logic [31:0]       rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;

  modport master (
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input bresp, bvalid, output bready,
    output araddr, arprot, arvalid, input arready,
    input rdata, rresp, rvalid, output rready
  );

  modport slave (
    input awaddr, awprot, awvalid, output awready,
    input wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );

endinterface

// File: rtl/axi4_lite_cmd_master.sv
// Single-outstanding AXI4-Lite initiator: one register command in, one full
// bus transaction out, one response back, plus a saturating error counter.
module axi4_lite_cmd_master
  import axi4_lite_cmd_master_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int ERR_CNT_W = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 cmd_valid_i,
  output logic                 cmd_ready_o,
  input  logic                 cmd_write_i,
  input  logic [ADDR_W-1:0]    cmd_addr_i,
  input  logic [31:0]          cmd_wdata_i,
  input  logic [3:0]           cmd_wstrb_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic                 rsp_write_o,
  output logic [31:0]          rsp_rdata_o,
  output logic [1:0]           rsp_resp_o,
  output logic                 busy_o,
  output logic [ERR_CNT_W-1:0] err_cnt_o,
  axi4_lite_if.master          csr_o
);

  state_e                state_reg;
  logic                  aw_valid_reg;
  logic                  w_valid_reg;
  logic                  ar_valid_reg;
  logic                  b_ready_reg;
  logic                  r_ready_reg;
  logic                  rsp_valid_reg;
  logic                  write_reg;
  logic [ADDR_W-1:0]     addr_reg;
  logic [31:0]           wdata_reg;
  logic [3:0]            wstrb_reg;
  logic [31:0]           rdata_reg;
  logic [1:0]            resp_reg;
  logic [ERR_CNT_W-1:0]  err_cnt_reg;

  logic aw_hs;
  logic w_hs;
  logic b_hs;
  logic r_hs;
  logic aw_done;
  logic w_done;
  logic err_event;

  assign aw_hs = aw_valid_reg & csr_o.awready;
  assign w_hs  = w_valid_reg & csr_o.wready;
  assign b_hs  = b_ready_reg & csr_o.bvalid;
  assign r_hs  = r_ready_reg & csr_o.rvalid;

  // Inside WR a dropped valid means that channel already completed.
  assign aw_done = !aw_valid_reg || aw_hs;
  assign w_done  = !w_valid_reg || w_hs;

  assign err_event = (b_hs && resp_is_err(csr_o.bresp)) ||
                     (r_hs && resp_is_err(csr_o.rresp));

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_reg     <= IDLE;
      aw_valid_reg  <= 1'b0;
      w_valid_reg   <= 1'b0;
      ar_valid_reg  <= 1'b0;
      b_ready_reg   <= 1'b0;
      r_ready_reg   <= 1'b0;
      rsp_valid_reg <= 1'b0;
      write_reg     <= 1'b0;
      addr_reg      <= '0;
      wdata_reg     <= '0;
      wstrb_reg     <= '0;
      rdata_reg     <= '0;
      resp_reg      <= '0;
      err_cnt_reg   <= '0;
    end else begin
      if (err_event && (err_cnt_reg != '1)) begin
        err_cnt_reg <= err_cnt_reg + ERR_CNT_W'(1);
      end

      case (state_reg)
        IDLE: begin
          if (cmd_valid_i) begin
            write_reg <= cmd_write_i;
            addr_reg  <= cmd_addr_i;
            wdata_reg <= cmd_wdata_i;
            wstrb_reg <= cmd_wstrb_i;
            if (cmd_write_i) begin
              aw_valid_reg <= 1'b1;
              w_valid_reg  <= 1'b1;
              state_reg    <= WR;
            end else begin
              ar_valid_reg <= 1'b1;
              state_reg    <= RD_A;
            end
          end
        end

        WR: begin
          if (aw_hs) aw_valid_reg <= 1'b0;
          if (w_hs)  w_valid_reg  <= 1'b0;
          if (aw_done && w_done) begin
            b_ready_reg <= 1'b1;
            state_reg   <= WR_B;
          end
        end

        WR_B: begin
          if (b_hs) begin
            resp_reg      <= csr_o.bresp;
            rdata_reg     <= '0;
            b_ready_reg   <= 1'b0;
            rsp_valid_reg <= 1'b1;
            state_reg     <= RSP;
          end
        end

        RD_A: begin
          if (ar_valid_reg && csr_o.arready) begin
            ar_valid_reg <= 1'b0;
            r_ready_reg  <= 1'b1;
            state_reg    <= RD_D;
          end
        end

        RD_D: begin
          if (r_hs) begin
            rdata_reg     <= csr_o.rdata;
            resp_reg      <= csr_o.rresp;
            r_ready_reg   <= 1'b0;
            rsp_valid_reg <= 1'b1;
            state_reg     <= RSP;
          end
        end

        RSP: begin
          if (rsp_ready_i) begin
            rsp_valid_reg <= 1'b0;
            state_reg     <= IDLE;
          end
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

  assign cmd_ready_o = (state_reg == IDLE);
  assign busy_o      = (state_reg != IDLE);
  assign rsp_valid_o = rsp_valid_reg;
  assign rsp_write_o = write_reg;
  assign rsp_rdata_o = rdata_reg;
  assign rsp_resp_o  = resp_reg;
  assign err_cnt_o   = err_cnt_reg;

  assign csr_o.awaddr  = addr_reg;
  assign csr_o.awprot  = 3'b000;
  assign csr_o.awvalid = aw_valid_reg;
  assign csr_o.wdata   = wdata_reg;
  assign csr_o.wstrb   = wstrb_reg;
  assign csr_o.wvalid  = w_valid_reg;
  assign csr_o.bready  = b_ready_reg;
  assign csr_o.araddr  = addr_reg;
  assign csr_o.arprot  = 3'b000;
  assign csr_o.arvalid = ar_valid_reg;
  assign csr_o.rready  = r_ready_reg;

endmodule

// File: tb/tb_axi4_lite_cmd_master.sv
// Bench for axi4_lite_cmd_master: register-file slave model on the bus, and a
// command-level reference model predicting every response and the error count.
module tb_axi4_lite_cmd_master;

  localparam int ADDR_W  = 32;
  localparam int ERR_W   = 3;
  localparam int ERR_MAX = 7;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n;
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [31:0]       cmd_addr;
  logic [31:0]       cmd_wdata;
  logic [3:0]        cmd_wstrb;
  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_write;
  logic [31:0]       rsp_rdata;
  logic [1:0]        rsp_resp;
  logic              busy;
  logic [ERR_W-1:0]  err_cnt;

  axi4_lite_if #(.ADDR_W(ADDR_W)) bus ();

  axi4_lite_cmd_master #(.ADDR_W(ADDR_W), .ERR_CNT_W(ERR_W)) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .cmd_valid_i (cmd_valid),
    .cmd_ready_o (cmd_ready),
    .cmd_write_i (cmd_write),
    .cmd_addr_i  (cmd_addr),
    .cmd_wdata_i (cmd_wdata),
    .cmd_wstrb_i (cmd_wstrb),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_write_o (rsp_write),
    .rsp_rdata_o (rsp_rdata),
    .rsp_resp_o  (rsp_resp),
    .busy_o      (busy),
    .err_cnt_o   (err_cnt),
    .csr_o       (bus)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- slave model ----------------
  // Map: 0x00-0x3F register file, 0x40-0x7F SLVERR, 0x80+ DECERR.
  int   ready_mode = 0;   // 0 zero-wait, 1 wready delayed 3 cycles after aw, 2 random
  logic hold_b     = 1'b0;
  logic [31:0] slv_mem [16];
  logic        aw_have, w_have;
  logic [31:0] aw_addr_l, w_data_l;
  logic [3:0]  w_strb_l;
  int          wdcnt;

  wire s_aw_hs = bus.awvalid & bus.awready;
  wire s_w_hs  = bus.wvalid & bus.wready;
  wire s_b_hs  = bus.bvalid & bus.bready;
  wire s_ar_hs = bus.arvalid & bus.arready;
  wire s_r_hs  = bus.rvalid & bus.rready;
  wire [31:0] s_waddr = s_aw_hs ? bus.awaddr : aw_addr_l;
  wire [31:0] s_wdata = s_w_hs ? bus.wdata : w_data_l;
  wire [3:0]  s_wstrb = s_w_hs ? bus.wstrb : w_strb_l;

  function automatic logic [1:0] slave_decode(input logic [31:0] a);
    if (a < 32'h40)      return 2'b00;
    else if (a < 32'h80) return 2'b10;
    else                 return 2'b11;
  endfunction

  always @(negedge clk) begin
    case (ready_mode)
      1: begin
        bus.awready = 1'b1;
        bus.arready = 1'b1;
        bus.wready  = (wdcnt >= 3);
      end
      2: begin
        bus.awready = 1'($urandom_range(0, 1));
        bus.arready = 1'($urandom_range(0, 1));
        bus.wready  = 1'($urandom_range(0, 1));
      end
      default: begin
        bus.awready = 1'b1;
        bus.arready = 1'b1;
        bus.wready  = 1'b1;
      end
    endcase
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.bvalid <= 1'b0;
      bus.bresp  <= 2'b00;
      bus.rvalid <= 1'b0;
      bus.rresp  <= 2'b00;
      bus.rdata  <= 32'h0;
      aw_have    <= 1'b0;
      w_have     <= 1'b0;
      aw_addr_l  <= 32'h0;
      w_data_l   <= 32'h0;
      w_strb_l   <= 4'h0;
      wdcnt      <= 0;
      for (int i = 0; i < 16; i++) slv_mem[i] <= 32'h0;
    end else begin
      if (s_b_hs) bus.bvalid <= 1'b0;
      if (s_r_hs) bus.rvalid <= 1'b0;

      if (s_w_hs)       wdcnt <= 0;
      else if (s_aw_hs) wdcnt <= 1;
      else if (wdcnt != 0) wdcnt <= wdcnt + 1;

      if ((aw_have || s_aw_hs) && (w_have || s_w_hs)) begin
        if (slave_decode(s_waddr) == 2'b00) begin
          for (int i = 0; i < 4; i++)
            if (s_wstrb[i]) slv_mem[s_waddr[5:2]][8*i +: 8] <= s_wdata[8*i +: 8];
        end
        bus.bresp <= slave_decode(s_waddr);
        if (!hold_b) bus.bvalid <= 1'b1;
        aw_have <= 1'b0;
        w_have  <= 1'b0;
      end else begin
        if (s_aw_hs) begin
          aw_have   <= 1'b1;
          aw_addr_l <= bus.awaddr;
        end
        if (s_w_hs) begin
          w_have   <= 1'b1;
          w_data_l <= bus.wdata;
          w_strb_l <= bus.wstrb;
        end
      end

      if (s_ar_hs) begin
        bus.rvalid <= 1'b1;
        bus.rresp  <= slave_decode(bus.araddr);
        bus.rdata  <= (slave_decode(bus.araddr) == 2'b00) ? slv_mem[bus.araddr[5:2]] : 32'h0;
      end
    end
  end

  // ---------------- bus monitor ----------------
  int n_aw = 0, n_w = 0, n_b = 0, n_ar = 0, n_r = 0, ar_hi = 0;
  int stab_viol = 0, prot_viol = 0;
  logic        prev_awvalid = 1'b0, prev_aw_hs = 1'b0, prev_wvalid = 1'b0, prev_w_hs = 1'b0;
  logic [31:0] prev_awaddr = 32'h0, prev_wdata = 32'h0;
  logic [3:0]  prev_wstrb = 4'h0;
  logic [31:0] last_awaddr = 32'h0, last_wdata = 32'h0, last_araddr = 32'h0;
  logic [3:0]  last_wstrb = 4'h0;

  always @(posedge clk) begin
    if (rst_n) begin
      if (s_aw_hs) begin n_aw <= n_aw + 1; last_awaddr <= bus.awaddr; end
      if (s_w_hs)  begin n_w <= n_w + 1; last_wdata <= bus.wdata; last_wstrb <= bus.wstrb; end
      if (s_b_hs)  n_b <= n_b + 1;
      if (s_ar_hs) begin n_ar <= n_ar + 1; last_araddr <= bus.araddr; end
      if (s_r_hs)  n_r <= n_r + 1;
      if (bus.arvalid) ar_hi <= ar_hi + 1;
      if ((bus.awvalid && prev_awvalid && !prev_aw_hs && bus.awaddr != prev_awaddr) ||
          (bus.wvalid && prev_wvalid && !prev_w_hs &&
           (bus.wdata != prev_wdata || bus.wstrb != prev_wstrb)))
        stab_viol <= stab_viol + 1;
      if (bus.awprot != 3'b000 || bus.arprot != 3'b000) prot_viol <= prot_viol + 1;
    end
    prev_awvalid <= bus.awvalid;
    prev_aw_hs   <= s_aw_hs;
    prev_awaddr  <= bus.awaddr;
    prev_wvalid  <= bus.wvalid;
    prev_w_hs    <= s_w_hs;
    prev_wdata   <= bus.wdata;
    prev_wstrb   <= bus.wstrb;
  end

  // ---------------- reference model + checking ----------------
  logic [31:0] model_mem [16];
  int          exp_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) model_mem[i] = 32'h0;
    exp_err = 0;
  endtask

  // Issue one command, check its response, then release it after 'hold' cycles.
  task automatic run_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] strb, input int hold, input bit chk_lat,
                         input bit keep_valid, output int accept_wait);
    logic [31:0] exp_rdata;
    logic [1:0]  exp_resp;
    logic [3:0]  idx;
    logic        bad;
    logic        s_write;
    logic [31:0] s_rdata;
    logic [1:0]  s_resp;
    int          n, c0, bus0;

    idx = addr[5:2];
    exp_resp = (addr < 32'h40) ? 2'b00 : ((addr < 32'h80) ? 2'b10 : 2'b11);
    if (wr) begin
      exp_rdata = 32'h0;
      if (exp_resp == 2'b00)
        for (int i = 0; i < 4; i++)
          if (strb[i]) model_mem[idx][8*i +: 8] = data[8*i +: 8];
    end else begin
      exp_rdata = (exp_resp == 2'b00) ? model_mem[idx] : 32'h0;
    end
    if (exp_resp != 2'b00 && exp_err < ERR_MAX) exp_err++;

    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = data;
    cmd_wstrb = strb;
    cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    accept_wait = n;
    chk("cmd_accept", 32'(cmd_ready), 32'd1);
    c0 = cyc;
    @(posedge clk); #1;
    if (!keep_valid) cmd_valid = 1'b0;

    n = 0;
    while (!rsp_valid && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("rsp_arrive", 32'(rsp_valid), 32'd1);
    if (chk_lat) chk("latency", 32'(cyc - c0), 32'd3);
    chk("rsp_write", 32'(rsp_write), 32'(wr));
    chk("rsp_rdata", rsp_rdata, exp_rdata);
    chk("rsp_resp", 32'(rsp_resp), 32'(exp_resp));
    chk("err_cnt", 32'(err_cnt), 32'(exp_err));
    if (wr) begin
      chk("awaddr", last_awaddr, addr);
      chk("wdata", last_wdata, data);
      chk("wstrb", 32'(last_wstrb), 32'(strb));
    end else begin
      chk("araddr", last_araddr, addr);
    end

    if (hold > 0) begin
      s_write = rsp_write;
      s_rdata = rsp_rdata;
      s_resp  = rsp_resp;
      bus0    = n_aw + n_w + n_ar + n_b + n_r;
      bad     = 1'b0;
      repeat (hold) begin
        @(posedge clk); #1;
        if (!rsp_valid || rsp_write !== s_write || rsp_rdata !== s_rdata ||
            rsp_resp !== s_resp || cmd_ready !== 1'b0)
          bad = 1'b1;
      end
      chk("rsp_hold_stable", 32'(bad), 32'd0);
      chk("rsp_hold_no_bus", 32'(n_aw + n_w + n_ar + n_b + n_r - bus0), 32'd0);
    end

    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("rsp_released", 32'(rsp_valid), 32'd0);
    chk("cmd_ready_after_rsp", 32'(cmd_ready), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int b0, aw0, w0, ar0;
    logic [31:0] a, d;

    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = 32'h0;
    cmd_wdata = 32'h0;
    cmd_wstrb = 4'h0;
    rsp_ready = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_err_cnt", 32'(err_cnt), 32'd0);
    chk("rst_axi_valids", 32'({bus.awvalid, bus.wvalid, bus.arvalid, bus.bready, bus.rready}), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Zero-wait write then read, with latency checks.
    run_cmd(1'b1, 32'h0, 32'h0000_0001, 4'hF, 0, 1'b1, 1'b0, w);
    chk("slave_reg0", slv_mem[0], 32'h0000_0001);
    chk("one_aw_w_b", 32'({n_aw[7:0], n_w[7:0], n_b[7:0]}), 32'h00_01_01_01);
    run_cmd(1'b1, 32'h4, 32'h0000_0003, 4'hF, 0, 1'b1, 1'b0, w);
    ar0 = ar_hi;
    run_cmd(1'b0, 32'h4, 32'h0, 4'h0, 0, 1'b1, 1'b0, w);
    chk("arvalid_one_cycle", 32'(ar_hi - ar0), 32'd1);

    // wready lags awready by three cycles.
    ready_mode = 1;
    aw0 = n_aw; w0 = n_w; b0 = n_b;
    run_cmd(1'b1, 32'h8, 32'hA5A5_1234, 4'hF, 0, 1'b0, 1'b0, w);
    chk("wdelay_one_aw", 32'(n_aw - aw0), 32'd1);
    chk("wdelay_one_w", 32'(n_w - w0), 32'd1);
    chk("wdelay_one_b", 32'(n_b - b0), 32'd1);
    ready_mode = 0;
    run_cmd(1'b0, 32'h8, 32'h0, 4'h0, 0, 1'b1, 1'b0, w);
    run_cmd(1'b1, 32'h8, 32'hFFFF_FFFF, 4'b0101, 0, 1'b1, 1'b0, w);
    run_cmd(1'b0, 32'h8, 32'h0, 4'h0, 0, 1'b1, 1'b0, w);

    // Three SLVERR writes, then OKAY.
    run_cmd(1'b1, 32'h40, 32'h1111_1111, 4'hF, 0, 1'b1, 1'b0, w);
    run_cmd(1'b1, 32'h44, 32'h2222_2222, 4'hF, 0, 1'b1, 1'b0, w);
    run_cmd(1'b1, 32'h48, 32'h3333_3333, 4'hF, 0, 1'b1, 1'b0, w);
    run_cmd(1'b1, 32'h0, 32'h0000_0001, 4'hF, 0, 1'b1, 1'b0, w);
    chk("err_cnt_three", 32'(err_cnt), 32'd3);

    // Response back-pressure with the next command already waiting.
    run_cmd(1'b1, 32'hC, 32'h0BAD_F00D, 4'hF, 10, 1'b1, 1'b1, w);
    run_cmd(1'b0, 32'hC, 32'h0, 4'h0, 0, 1'b1, 1'b0, w);
    chk("accept_next_cycle", 32'(w), 32'd0);

    // Drive the counter into saturation, including DECERR reads.
    for (int i = 0; i < 5; i++)
      run_cmd(1'(i & 1), 32'h80 + 32'(i * 4), 32'h5555_0000 + 32'(i), 4'hF, 0, 1'b1, 1'b0, w);
    chk("err_cnt_saturated", 32'(err_cnt), 32'(ERR_MAX));

    // Random traffic with random ready behaviour and response delays.
    ready_mode = 2;
    for (int i = 0; i < 40; i++) begin
      a = 32'($urandom_range(0, 47)) << 2;
      d = $urandom;
      run_cmd(1'($urandom_range(0, 1)), a, d, 4'($urandom_range(0, 15)),
              $urandom_range(0, 3), 1'b0, 1'b0, w);
    end
    chk("random_no_stability_violation", 32'(stab_viol), 32'd0);
    chk("prot_zero", 32'(prot_viol), 32'd0);

    // Reset while waiting for the write response.
    ready_mode = 0;
    hold_b     = 1'b1;
    cmd_write  = 1'b1;
    cmd_addr   = 32'h80;
    cmd_wdata  = 32'hDEAD_BEEF;
    cmd_wstrb  = 4'hF;
    cmd_valid  = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    chk("reached_wr_b", 32'(bus.bready), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_valids", 32'({bus.bready, bus.awvalid, bus.wvalid}), 32'd0);
    chk("async_rst_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    rst_n  = 1'b1;
    hold_b = 1'b0;
    model_reset();
    @(posedge clk); #1;
    chk("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("post_rst_err_cnt", 32'(err_cnt), 32'd0);
    chk("post_rst_busy", 32'(busy), 32'd0);
    run_cmd(1'b1, 32'h10, 32'hCAFE_0042, 4'hF, 0, 1'b1, 1'b0, w);
    run_cmd(1'b0, 32'h10, 32'h0, 4'h0, 0, 1'b1, 1'b0, w);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
